// File: rtl/mem_request_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: per-channel FSM state encoding.
package mem_request_arbiter_pkg;

    localparam int unsigned CHAN_STATE_BITS = 3;

    typedef enum logic [CHAN_STATE_BITS-1:0] {
        ST_IDLE           = 3'd0,
        ST_READ_WAITING   = 3'd1,
        ST_WRITE_WAITING  = 3'd2,
        ST_READ_RELAYING  = 3'd3,
        ST_WRITE_RELAYING = 3'd4
    } mem_chan_state_t;

endpackage

// File: rtl/mem_channel_fsm.sv
// One memory channel: accepts a one-hot grant from the parent, captures the
// request, runs the memory handshake and holds the consumer-side ready.
//
// Handshake rules: mem_*_valid rises on grant and stays high until the memory
// returns its ready strobe; the consumer ready then stays high until the
// owning consumer's valid is seen low, at which point the channel releases
// its claim and returns to IDLE.
module mem_channel_fsm
    import mem_request_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CONSUMERS-1:0] i_grant,
    input  logic                     i_grant_read,
    input  logic [ADDR_BITS-1:0]     i_grant_addr,
    input  logic [DATA_BITS-1:0]     i_grant_data,
    input  logic [NUM_CONSUMERS-1:0] i_consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0] i_consumer_write_valid,
    input  logic                     i_mem_read_ready,
    input  logic                     i_mem_write_ready,
    output mem_chan_state_t          o_state,
    output logic [NUM_CONSUMERS-1:0] o_owner,
    output logic                     o_read_done,
    output logic [NUM_CONSUMERS-1:0] o_release,
    output logic                     o_mem_read_valid,
    output logic [ADDR_BITS-1:0]     o_mem_read_address,
    output logic                     o_mem_write_valid,
    output logic [ADDR_BITS-1:0]     o_mem_write_address,
    output logic [DATA_BITS-1:0]     o_mem_write_data,
    output logic                     o_read_ready,
    output logic                     o_write_ready
);

    localparam bit WRITE_EN = (WRITE_ENABLE != 0);

    mem_chan_state_t            r_state;
    logic [NUM_CONSUMERS-1:0]   r_owner;
    logic                       r_mem_read_valid;
    logic [ADDR_BITS-1:0]       r_mem_read_address;
    logic                       r_mem_write_valid;
    logic [ADDR_BITS-1:0]       r_mem_write_address;
    logic [DATA_BITS-1:0]       r_mem_write_data;
    logic                       r_read_ready;
    logic                       r_write_ready;

    logic                       w_owner_read_valid;
    logic                       w_owner_write_valid;
    logic                       w_releasing;

    assign w_owner_read_valid  = |(r_owner & i_consumer_read_valid);
    assign w_owner_write_valid = |(r_owner & i_consumer_write_valid);
    assign w_releasing = ((r_state == ST_READ_RELAYING)  && !w_owner_read_valid) ||
                         ((r_state == ST_WRITE_RELAYING) && !w_owner_write_valid);

    assign o_state             = r_state;
    assign o_owner             = r_owner;
    assign o_read_done         = (r_state == ST_READ_WAITING) && i_mem_read_ready;
    assign o_release           = w_releasing ? r_owner : '0;
    assign o_mem_read_valid    = r_mem_read_valid;
    assign o_mem_read_address  = r_mem_read_address;
    assign o_mem_write_valid   = r_mem_write_valid;
    assign o_mem_write_address = r_mem_write_address;
    assign o_mem_write_data    = r_mem_write_data;
    assign o_read_ready        = r_read_ready;
    assign o_write_ready       = r_write_ready;

    // Channel state machine with registered memory-side and consumer-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state             <= ST_IDLE;
            r_owner             <= '0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_read_ready        <= 1'b0;
            r_write_ready       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_grant) begin
                        r_owner <= i_grant;
                        if (i_grant_read) begin
                            r_mem_read_valid   <= 1'b1;
                            r_mem_read_address <= i_grant_addr;
                            r_state            <= ST_READ_WAITING;
                        end else if (WRITE_EN) begin
                            r_mem_write_valid   <= 1'b1;
                            r_mem_write_address <= i_grant_addr;
                            r_mem_write_data    <= i_grant_data;
                            r_state             <= ST_WRITE_WAITING;
                        end
                    end
                end
                ST_READ_WAITING: begin
                    if (i_mem_read_ready) begin
                        r_mem_read_valid <= 1'b0;
                        r_read_ready     <= 1'b1;
                        r_state          <= ST_READ_RELAYING;
                    end
                end
                ST_WRITE_WAITING: begin
                    if (i_mem_write_ready) begin
                        r_mem_write_valid <= 1'b0;
                        r_write_ready     <= 1'b1;
                        r_state           <= ST_WRITE_RELAYING;
                    end
                end
                ST_READ_RELAYING: begin
                    if (!w_owner_read_valid) begin
                        r_read_ready <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_WRITE_RELAYING: begin
                    if (!w_owner_write_valid) begin
                        r_write_ready <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Collects consumer read/write requests and spreads them over NUM_CHANNELS
// memory channels with fixed lowest-index-first priority; relays responses back.
module mem_request_arbiter
    import mem_request_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    output logic [NUM_CHANNELS*CHAN_STATE_BITS-1:0] dbg_chan_state
);

    localparam bit WRITE_EN = (WRITE_ENABLE != 0);

    logic [NUM_CONSUMERS-1:0]                    r_claim;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     r_read_data;

    logic [NUM_CONSUMERS-1:0]                    w_pending;
    logic [NUM_CONSUMERS-1:0]                    w_taken;
    logic [NUM_CONSUMERS-1:0]                    w_grant_any;
    logic [NUM_CONSUMERS-1:0]                    w_release_any;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  w_avail;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  w_grant;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  w_owner;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  w_release;
    logic [NUM_CHANNELS-1:0]                     w_chan_idle;
    logic [NUM_CHANNELS-1:0]                     w_grant_read;
    logic [NUM_CHANNELS-1:0]                     w_read_done;
    logic [NUM_CHANNELS-1:0]                     w_read_ready_ch;
    logic [NUM_CHANNELS-1:0]                     w_write_ready_ch;
    logic [NUM_CHANNELS-1:0]                     w_mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      w_grant_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      w_grant_data;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      w_mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      w_mem_write_data;
    mem_chan_state_t                             w_state [NUM_CHANNELS];

    // With writes disabled, write requests never count as pending work.
    assign w_pending = consumer_read_valid | (WRITE_EN ? consumer_write_valid : '0);

    // Cascaded grant: each idle channel takes the lowest unclaimed pending consumer not taken by a lower channel.
    always_comb begin
        w_taken      = '0;
        w_avail      = '0;
        w_grant      = '0;
        w_grant_read = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_avail[c] = w_pending & ~r_claim & ~w_taken;
            if (w_chan_idle[c]) begin
                w_grant[c] = w_avail[c] & (~w_avail[c] + NUM_CONSUMERS'(1));
            end
            w_grant_read[c] = |(w_grant[c] & consumer_read_valid);
            w_taken         = w_taken | w_grant[c];
        end
    end

    // Select the granted consumer's address/data for each channel to capture.
    always_comb begin
        w_grant_addr = '0;
        w_grant_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                if (w_grant[c][i]) begin
                    w_grant_addr[c] = w_grant_read[c] ? consumer_read_address[i*ADDR_BITS +: ADDR_BITS]
                                                      : consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                    w_grant_data[c] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

    // Collapse per-channel grants and releases into per-consumer masks.
    always_comb begin
        w_grant_any   = '0;
        w_release_any = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_grant_any   = w_grant_any | w_grant[c];
            w_release_any = w_release_any | w_release[c];
        end
    end

    // Claim vector: set when a channel grabs a consumer, cleared when that channel releases it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_claim <= '0;
        end else begin
            r_claim <= (r_claim | w_grant_any) & ~w_release_any;
        end
    end

    // Per-consumer read data holds until the next completed read for that consumer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read_data <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    if (w_read_done[c] && w_owner[c][i]) begin
                        r_read_data[i] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
                    end
                end
            end
        end
    end

    assign consumer_read_data = r_read_data;

    // Route each channel's registered ready back to the consumer it owns.
    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                if (w_owner[c][i]) begin
                    consumer_read_ready[i]  = consumer_read_ready[i] | w_read_ready_ch[c];
                    consumer_write_ready[i] = consumer_write_ready[i] | w_write_ready_ch[c];
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        mem_channel_fsm #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .WRITE_ENABLE  (WRITE_ENABLE)
        ) u_fsm (
            .clk                    (clk),
            .reset_n                (reset_n),
            .i_grant                (w_grant[c]),
            .i_grant_read           (w_grant_read[c]),
            .i_grant_addr           (w_grant_addr[c]),
            .i_grant_data           (w_grant_data[c]),
            .i_consumer_read_valid  (consumer_read_valid),
            .i_consumer_write_valid (consumer_write_valid),
            .i_mem_read_ready       (mem_read_ready[c]),
            .i_mem_write_ready      (mem_write_ready[c]),
            .o_state                (w_state[c]),
            .o_owner                (w_owner[c]),
            .o_read_done            (w_read_done[c]),
            .o_release              (w_release[c]),
            .o_mem_read_valid       (mem_read_valid[c]),
            .o_mem_read_address     (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
            .o_mem_write_valid      (w_mem_write_valid[c]),
            .o_mem_write_address    (w_mem_write_address[c]),
            .o_mem_write_data       (w_mem_write_data[c]),
            .o_read_ready           (w_read_ready_ch[c]),
            .o_write_ready          (w_write_ready_ch[c])
        );

        assign w_chan_idle[c] = (w_state[c] == ST_IDLE);
        assign dbg_chan_state[c*CHAN_STATE_BITS +: CHAN_STATE_BITS] = w_state[c];

        // Program-memory instances tie every write output low.
        assign mem_write_valid[c]                            = WRITE_EN ? w_mem_write_valid[c] : 1'b0;
        assign mem_write_address[c*ADDR_BITS +: ADDR_BITS]   = WRITE_EN ? w_mem_write_address[c] : '0;
        assign mem_write_data[c*DATA_BITS +: DATA_BITS]      = WRITE_EN ? w_mem_write_data[c] : '0;
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench: a two-channel data-memory instance and a one-channel
// program-memory instance, each answered by a registered memory model.
module tb_mem_request_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // Data-memory instance: 4 consumers, 2 channels, 8-bit data, writes on.
    logic [3:0]  dd_crv, dd_crr, dd_cwv, dd_cwr;
    logic [31:0] dd_cra, dd_crd, dd_cwa, dd_cwd;
    logic [1:0]  dd_mrv, dd_mrr, dd_mwv, dd_mwr;
    logic [15:0] dd_mra, dd_mrd, dd_mwa, dd_mwd;
    logic [5:0]  dd_dbg;

    // Program-memory instance: 4 consumers, 1 channel, 16-bit data, writes off.
    logic [3:0]  pm_crv, pm_crr, pm_cwv, pm_cwr;
    logic [31:0] pm_cra, pm_cwa;
    logic [63:0] pm_crd, pm_cwd;
    logic [0:0]  pm_mrv, pm_mrr, pm_mwv, pm_mwr;
    logic [7:0]  pm_mra, pm_mwa;
    logic [15:0] pm_mrd, pm_mwd;
    logic [2:0]  pm_dbg;

    mem_request_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1)
    ) u_dd (
        .clk(clk), .reset_n(reset_n),
        .consumer_read_valid(dd_crv), .consumer_read_address(dd_cra),
        .consumer_read_ready(dd_crr), .consumer_read_data(dd_crd),
        .consumer_write_valid(dd_cwv), .consumer_write_address(dd_cwa),
        .consumer_write_data(dd_cwd), .consumer_write_ready(dd_cwr),
        .mem_read_valid(dd_mrv), .mem_read_address(dd_mra),
        .mem_read_ready(dd_mrr), .mem_read_data(dd_mrd),
        .mem_write_valid(dd_mwv), .mem_write_address(dd_mwa),
        .mem_write_data(dd_mwd), .mem_write_ready(dd_mwr),
        .dbg_chan_state(dd_dbg)
    );

    mem_request_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(0)
    ) u_pm (
        .clk(clk), .reset_n(reset_n),
        .consumer_read_valid(pm_crv), .consumer_read_address(pm_cra),
        .consumer_read_ready(pm_crr), .consumer_read_data(pm_crd),
        .consumer_write_valid(pm_cwv), .consumer_write_address(pm_cwa),
        .consumer_write_data(pm_cwd), .consumer_write_ready(pm_cwr),
        .mem_read_valid(pm_mrv), .mem_read_address(pm_mra),
        .mem_read_ready(pm_mrr), .mem_read_data(pm_mrd),
        .mem_write_valid(pm_mwv), .mem_write_address(pm_mwa),
        .mem_write_data(pm_mwd), .mem_write_ready(pm_mwr),
        .dbg_chan_state(pm_dbg)
    );

    // Data memory: contents reset to addr ^ 0x39; ready is a one-cycle registered strobe.
    logic [7:0] dmem [256];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dd_mrr <= '0;
            dd_mwr <= '0;
            dd_mrd <= '0;
            for (int i = 0; i < 256; i++) dmem[i] <= 8'(i) ^ 8'h39;
        end else begin
            for (int c = 0; c < 2; c++) begin
                dd_mrr[c]        <= dd_mrv[c] & ~dd_mrr[c];
                dd_mrd[c*8 +: 8] <= dmem[dd_mra[c*8 +: 8]];
                dd_mwr[c]        <= dd_mwv[c] & ~dd_mwr[c];
                if (dd_mwv[c] && !dd_mwr[c]) dmem[dd_mwa[c*8 +: 8]] <= dd_mwd[c*8 +: 8];
            end
        end
    end

    // Program memory: word = {addr ^ 0x58, 0x0D}; never acknowledges writes.
    assign pm_mwr = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pm_mrr <= '0;
            pm_mrd <= '0;
        end else begin
            pm_mrr <= pm_mrv & ~pm_mrr;
            pm_mrd <= {pm_mra ^ 8'h58, 8'h0D};
        end
    end

    // Any cycle where program-memory write valid is not 0 is recorded.
    int pm_wr_bad = 0;
    always @(negedge clk) if (pm_mwv !== 1'b0) pm_wr_bad++;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        dd_crv = '0; dd_cra = '0; dd_cwv = '0; dd_cwa = '0; dd_cwd = '0;
        pm_crv = '0; pm_cra = '0; pm_cwv = '0; pm_cwa = '0; pm_cwd = '0;
        tick(); tick();
        check("rst_dd_mrv", 64'(dd_mrv), 64'h0);
        check("rst_dd_mwv", 64'(dd_mwv), 64'h0);
        check("rst_dd_crr", 64'(dd_crr), 64'h0);
        check("rst_dd_cwr", 64'(dd_cwr), 64'h0);
        check("rst_dd_crd", 64'(dd_crd), 64'h0);
        check("rst_dd_dbg", 64'(dd_dbg), 64'h0);
        check("rst_pm_mrv", 64'(pm_mrv), 64'h0);
        reset_n = 1'b1;
        tick();

        // Single read: consumer 2 reads 0x05 (holds 0x3C).
        dd_cra[23:16] = 8'h05; dd_crv = 4'b0100;
        tick();
        check("single_mrv", 64'(dd_mrv), 64'h1);
        check("single_mra", 64'(dd_mra[7:0]), 64'h05);
        check("single_dbg", 64'(dd_dbg), 64'h01);
        tick();
        check("single_crr_early", 64'(dd_crr), 64'h0);
        tick();
        check("single_crr", 64'(dd_crr), 64'h4);
        check("single_crd", 64'(dd_crd[23:16]), 64'h3C);
        check("single_mrv_drop", 64'(dd_mrv), 64'h0);
        tick();
        check("single_crr_held", 64'(dd_crr), 64'h4);
        dd_crv = 4'b0000;
        tick();
        check("single_crr_off", 64'(dd_crr), 64'h0);
        check("single_idle", 64'(dd_dbg), 64'h0);
        check("single_crd_hold", 64'(dd_crd[23:16]), 64'h3C);

        // Simultaneous reads from all four consumers on two channels.
        dd_cra = {8'h23, 8'h22, 8'h21, 8'h20}; dd_crv = 4'b1111;
        tick();
        check("simul_mrv_c1", 64'(dd_mrv), 64'h3);
        check("simul_mra_c1", 64'(dd_mra), 64'h2120);
        tick();
        check("simul_mra_c2", 64'(dd_mra), 64'h2120);
        tick();
        check("simul_crr_01", 64'(dd_crr), 64'h3);
        check("simul_crd_01", 64'(dd_crd[15:0]), 64'h1819);
        check("simul_dbg_relay", 64'(dd_dbg), 64'h1B);
        dd_crv = 4'b1100;
        tick();
        check("simul_crr_gap", 64'(dd_crr), 64'h0);
        check("simul_mrv_gap", 64'(dd_mrv), 64'h0);
        tick();
        check("simul_mrv_23", 64'(dd_mrv), 64'h3);
        check("simul_mra_23", 64'(dd_mra), 64'h2322);
        tick(); tick();
        check("simul_crr_23", 64'(dd_crr), 64'hC);
        check("simul_crd_23", 64'(dd_crd[31:16]), 64'h1A1B);
        check("simul_crd_01_hold", 64'(dd_crd[15:0]), 64'h1819);
        dd_crv = 4'b0000;
        tick();
        check("simul_crr_off", 64'(dd_crr), 64'h0);

        // Write 0xA5 to 0x10 from consumer 1, then read it back.
        dd_cwa[15:8] = 8'h10; dd_cwd[15:8] = 8'hA5; dd_cwv = 4'b0010;
        tick();
        check("wr_mwv", 64'(dd_mwv), 64'h1);
        check("wr_mwa", 64'(dd_mwa[7:0]), 64'h10);
        check("wr_mwd", 64'(dd_mwd[7:0]), 64'hA5);
        check("wr_mrv", 64'(dd_mrv), 64'h0);
        dd_cwa[15:8] = 8'h99; dd_cwd[15:8] = 8'hFF;
        tick();
        check("wr_capture_a", 64'(dd_mwa[7:0]), 64'h10);
        check("wr_capture_d", 64'(dd_mwd[7:0]), 64'hA5);
        tick();
        check("wr_cwr", 64'(dd_cwr), 64'h2);
        check("wr_mwv_drop", 64'(dd_mwv), 64'h0);
        dd_cwv = 4'b0000;
        tick();
        check("wr_cwr_off", 64'(dd_cwr), 64'h0);
        dd_cra[15:8] = 8'h10; dd_crv = 4'b0010;
        tick();
        check("rdback_mra", 64'(dd_mra[7:0]), 64'h10);
        tick(); tick();
        check("rdback_crr", 64'(dd_crr), 64'h2);
        check("rdback_crd", 64'(dd_crd[15:8]), 64'hA5);
        dd_crv = 4'b0000;
        tick();

        // Read and write together on consumer 0: read first, write afterwards.
        dd_cra[7:0] = 8'h01; dd_cwa[7:0] = 8'h02; dd_cwd[7:0] = 8'h77;
        dd_crv = 4'b0001; dd_cwv = 4'b0001;
        tick();
        check("rw_mrv", 64'(dd_mrv), 64'h1);
        check("rw_mwv_none", 64'(dd_mwv), 64'h0);
        check("rw_mra", 64'(dd_mra[7:0]), 64'h01);
        tick(); tick();
        check("rw_crr", 64'(dd_crr), 64'h1);
        check("rw_crd", 64'(dd_crd[7:0]), 64'h38);
        dd_crv = 4'b0000;
        tick();
        check("rw_crr_off", 64'(dd_crr), 64'h0);
        check("rw_mwv_wait", 64'(dd_mwv), 64'h0);
        tick();
        check("rw_mwv", 64'(dd_mwv), 64'h1);
        check("rw_mwa", 64'(dd_mwa[7:0]), 64'h02);
        check("rw_mwd", 64'(dd_mwd[7:0]), 64'h77);
        tick(); tick();
        check("rw_cwr", 64'(dd_cwr), 64'h1);
        dd_cwv = 4'b0000;
        tick();
        check("rw_cwr_off", 64'(dd_cwr), 64'h0);

        // Consumer 3 drops valid while waiting: ready pulses for one cycle.
        dd_cra[31:24] = 8'h05; dd_crv = 4'b1000;
        tick();
        check("drop_mrv", 64'(dd_mrv), 64'h1);
        dd_crv = 4'b0000;
        tick(); tick();
        check("drop_crr_pulse", 64'(dd_crr), 64'h8);
        check("drop_crd", 64'(dd_crd[31:24]), 64'h3C);
        tick();
        check("drop_crr_off", 64'(dd_crr), 64'h0);
        check("drop_idle", 64'(dd_dbg), 64'h0);

        // Reset while channel 0 is in READ_WAITING.
        dd_cra[23:16] = 8'h20; dd_crv = 4'b0100;
        tick();
        check("rstmid_mrv_pre", 64'(dd_mrv), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_mrv", 64'(dd_mrv), 64'h0);
        check("rstmid_crr", 64'(dd_crr), 64'h0);
        check("rstmid_cwr", 64'(dd_cwr), 64'h0);
        check("rstmid_dbg", 64'(dd_dbg), 64'h0);
        dd_crv = 4'b0000;
        tick();
        reset_n = 1'b1;
        tick();
        check("rstmid_quiet", 64'(dd_mrv), 64'h0);
        dd_crv = 4'b0100;
        tick();
        check("rstmid_regrant", 64'(dd_mrv), 64'h1);
        check("rstmid_mra", 64'(dd_mra[7:0]), 64'h20);
        tick(); tick();
        check("rstmid_crr", 64'(dd_crr), 64'h4);
        check("rstmid_crd", 64'(dd_crd[23:16]), 64'h19);
        dd_crv = 4'b0000;
        tick();

        // Program memory: 16-bit fetch for consumer 1; write request on consumer 0 ignored.
        pm_cra[15:8] = 8'h07; pm_crv = 4'b0010;
        pm_cwa[7:0] = 8'h33; pm_cwd[15:0] = 16'hDEAD; pm_cwv = 4'b0001;
        tick();
        check("pm_mrv", 64'(pm_mrv), 64'h1);
        check("pm_mra", 64'(pm_mra), 64'h07);
        tick(); tick();
        check("pm_crr", 64'(pm_crr), 64'h2);
        check("pm_crd", 64'(pm_crd[31:16]), 64'h5F0D);
        check("pm_cwr", 64'(pm_cwr), 64'h0);
        pm_crv = 4'b0000;
        tick();
        check("pm_crr_off", 64'(pm_crr), 64'h0);
        pm_cwv = 4'b0000;
        tick();
        check("pm_no_write", 64'(pm_wr_bad), 64'h0);
        check("pm_mwa_zero", 64'(pm_mwa), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
